// File: rtl/pid_controller_pkg.sv
// Shared definitions for the PID motor controller: mode encodings, FSM
// states and the symmetric saturation helper.
package pid_controller_pkg;

  localparam logic [7:0] MODE_POSITION     = 8'd0;
  localparam logic [7:0] MODE_VELOCITY     = 8'd1;
  localparam logic [7:0] MODE_DISPLACEMENT = 8'd2;
  localparam logic [7:0] MODE_DIRECT       = 8'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_PMUL, S_IMUL, S_DMUL, S_SUM, S_OUT
  } state_t;

  // Clamp a signed value into [-lim, +lim]; lim is treated as unsigned.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input logic [62:0]        lim);
    logic signed [63:0] hi;
    hi = $signed({1'b0, lim});
    if (v > hi)  return hi;
    if (v < -hi) return -hi;
    return v;
  endfunction

endpackage

// File: rtl/pid_controller_tick.sv
// Free-running period counter; tick is high for the one cycle in which the
// counter sits at PERIOD-1 and is about to wrap.
module tick_gen #(
  parameter int PERIOD = 16000
) (
  input  logic CLK,
  input  logic reset,
  output logic tick
);
  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(PERIOD - 1));

  // Count 0..PERIOD-1 and wrap.
  always_ff @(posedge CLK) begin
    if (reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/pid_controller.sv
// Periodic PID loop: snapshots inputs on each tick, then walks a short FSM
// that time-shares one signed multiplier for the P, I and D products and
// publishes a saturated duty with a one-cycle update_done pulse.
import pid_controller_pkg::*;

module pid_controller #(
  parameter int UPDATE_PERIOD = 16000,
  parameter int DUTY_WIDTH    = 24
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic signed [DUTY_WIDTH-1:0] setpoint,
  input  logic [7:0]                   control_mode,
  input  logic signed [DUTY_WIDTH-1:0] Kp,
  input  logic signed [DUTY_WIDTH-1:0] Ki,
  input  logic signed [DUTY_WIDTH-1:0] Kd,
  input  logic [DUTY_WIDTH-1:0]        PWMLimit,
  input  logic [DUTY_WIDTH-1:0]        IntegralLimit,
  input  logic [DUTY_WIDTH-1:0]        deadband,
  input  logic signed [DUTY_WIDTH-1:0] encoder0_position,
  input  logic signed [DUTY_WIDTH-1:0] displacement,
  output logic signed [DUTY_WIDTH-1:0] duty,
  output logic                         update_done
);
  localparam int DW = DUTY_WIDTH;
  localparam int PW = 2*DW + 1;   // product width; D operand is DW+1 bits
  localparam int SW = 2*DW + 2;   // accumulation width
  localparam logic signed [DW:0] ERR_MAX = (DW+1)'(2**(DW-1) - 1);
  localparam logic signed [DW:0] ERR_MIN = (DW+1)'(-(2**(DW-1)));
  localparam logic [DW-1:0]      LIM_MAX = DW'(2**(DW-1) - 1);

  logic tick;
  tick_gen #(.PERIOD(UPDATE_PERIOD)) u_tick (.CLK(CLK), .reset(reset), .tick(tick));

  state_t state, state_nxt;

  logic signed [DW-1:0] sp_s, kp_s, ki_s, kd_s, meas_s, err_r, err_prev, sum_r, enc_prev;
  logic [DW-1:0]        pl_s, il_s, db_s;
  logic [7:0]           mode_s, mode_prev;
  logic                 enc_valid, mode_chg, pid_mode;
  logic signed [DW:0]   integral, integral_nxt;
  logic signed [PW-1:0] p_r, d_r, product;
  logic signed [DW-1:0] mul_a, meas_live, err_sat, err_db, duty_nxt;
  logic signed [DW:0]   mul_b, diff, abs_err;
  logic signed [SW-1:0] int_sum, pid_sum;
  logic [DW-1:0]        lim_eff;

  assign pid_mode = (mode_s <= MODE_DISPLACEMENT);

  // State register.
  always_ff @(posedge CLK) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Fixed walk through the compute states once a tick is seen in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (tick) state_nxt = S_ERR;
      S_ERR:   state_nxt = S_PMUL;
      S_PMUL:  state_nxt = S_IMUL;
      S_IMUL:  state_nxt = S_DMUL;
      S_DMUL:  state_nxt = S_SUM;
      S_SUM:   state_nxt = S_OUT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Measurement selection on live inputs, used only at the snapshot edge.
  always_comb begin
    meas_live = '0;
    case (control_mode)
      MODE_POSITION:     meas_live = encoder0_position;
      MODE_VELOCITY:     meas_live = enc_valid ? (encoder0_position - enc_prev) : '0;
      MODE_DISPLACEMENT: meas_live = displacement;
      default:           meas_live = '0;
    endcase
  end

  // Error: widen, saturate to DW bits, then apply the deadband.
  always_comb begin
    diff = (DW+1)'(sp_s) - (DW+1)'(meas_s);
    if (diff > ERR_MAX)      err_sat = DW'(ERR_MAX);
    else if (diff < ERR_MIN) err_sat = DW'(ERR_MIN);
    else                     err_sat = diff[DW-1:0];
    abs_err = err_sat[DW-1] ? -((DW+1)'(err_sat)) : (DW+1)'(err_sat);
    err_db  = (abs_err <= $signed({1'b0, db_s})) ? '0 : err_sat;
  end

  // Shared multiplier operand steering.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      S_PMUL: begin mul_a = kp_s; mul_b = (DW+1)'(err_r); end
      S_IMUL: begin mul_a = ki_s; mul_b = (DW+1)'(err_r); end
      S_DMUL: begin mul_a = kd_s; mul_b = (DW+1)'(err_r) - (DW+1)'(err_prev); end
      default: ;
    endcase
    product = PW'(mul_a) * PW'(mul_b);
  end

  // Integral update with anti-windup clamp, and the final output value.
  always_comb begin
    int_sum      = SW'(integral) + SW'(product);
    integral_nxt = (DW+1)'(sat_signed(64'(int_sum), 63'(il_s)));
    pid_sum      = SW'(p_r) + SW'(d_r) + SW'(integral);
    // duty cannot hold +2^(DW-1), so larger limits collapse to the max.
    lim_eff      = (pl_s > LIM_MAX) ? LIM_MAX : pl_s;
    if (pid_mode)                  duty_nxt = DW'(sat_signed(64'(pid_sum), 63'(lim_eff)));
    else if (mode_s == MODE_DIRECT) duty_nxt = DW'(sat_signed(64'(sp_s), 63'(lim_eff)));
    else                           duty_nxt = '0;
  end

  // Datapath registers advanced by FSM state.
  always_ff @(posedge CLK) begin
    if (reset) begin
      duty <= '0; update_done <= 1'b0; integral <= '0; err_prev <= '0;
      enc_prev <= '0; enc_valid <= 1'b0; mode_prev <= MODE_POSITION; mode_chg <= 1'b0;
      sp_s <= '0; kp_s <= '0; ki_s <= '0; kd_s <= '0; meas_s <= '0; mode_s <= '0;
      pl_s <= '0; il_s <= '0; db_s <= '0; err_r <= '0; p_r <= '0; d_r <= '0; sum_r <= '0;
    end else begin
      update_done <= 1'b0;
      case (state)
        S_IDLE: if (tick) begin
          sp_s <= setpoint; kp_s <= Kp; ki_s <= Ki; kd_s <= Kd;
          pl_s <= PWMLimit; il_s <= IntegralLimit; db_s <= deadband;
          mode_s <= control_mode; meas_s <= meas_live;
          mode_chg  <= (control_mode != mode_prev);
          mode_prev <= control_mode;
          enc_prev  <= encoder0_position;
          enc_valid <= 1'b1;
        end
        S_ERR: begin
          err_r <= err_db;
          // Fresh start after a mode switch; non-PID modes keep history at 0.
          if (mode_chg || !pid_mode) begin
            integral <= '0;
            err_prev <= '0;
          end
        end
        S_PMUL: p_r <= product;
        S_IMUL: if (pid_mode) integral <= integral_nxt;
        S_DMUL: begin
          d_r <= product;
          if (pid_mode) err_prev <= err_r;
        end
        S_SUM:  sum_r <= duty_nxt;
        S_OUT: begin
          duty        <= sum_r;
          update_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pid_controller.sv
// Directed bench for pid_controller with a short control period.
module tb_pid_controller;
  localparam int P = 16;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] setpoint, Kp, Ki, Kd, PWMLimit, IntegralLimit, deadband;
  logic [23:0] encoder0_position, displacement, duty;
  logic [7:0]  control_mode;
  logic        update_done;
  int          tests = 0;
  int          fails = 0;

  pid_controller #(.UPDATE_PERIOD(P), .DUTY_WIDTH(24)) dut (
    .CLK(CLK), .reset(reset), .setpoint(setpoint), .control_mode(control_mode),
    .Kp(Kp), .Ki(Ki), .Kd(Kd), .PWMLimit(PWMLimit), .IntegralLimit(IntegralLimit),
    .deadband(deadband), .encoder0_position(encoder0_position),
    .displacement(displacement), .duty(duty), .update_done(update_done)
  );

  always #5 CLK = ~CLK;

  // Wait for the next update_done; cyc = posedges waited, -1 on timeout.
  task automatic wait_update(output int cyc);
    cyc = 0;
    do begin
      @(posedge CLK); #1;
      cyc++;
    end while (!update_done && cyc < 3*P);
    if (!update_done) cyc = -1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    control_mode = 8'd0; setpoint = 24'd100; encoder0_position = 24'd0; displacement = 24'd0;
    Kp = 24'd10; Ki = 24'd0; Kd = 24'd0; PWMLimit = 24'd8388607;
    IntegralLimit = 24'd1000; deadband = 24'd0;
    repeat (3) @(posedge CLK);
    #1;
    tests++; if (duty !== 24'd0) begin fails++; $display("FAIL reset_duty: got %0d want 0", $signed(duty)); end
    tests++; if (update_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", update_done); end
  endtask

  task automatic test_p_basic;
    int cyc;
    @(negedge CLK) reset = 1'b0;
    wait_update(cyc);
    tests++; if (cyc != P + 6) begin fails++; $display("FAIL p_latency: got %0d cycles want %0d", cyc, P + 6); end
    tests++; if (duty !== 24'd1000) begin fails++; $display("FAIL p_duty: got %0d want 1000", $signed(duty)); end
    @(posedge CLK); #1;
    tests++; if (update_done !== 1'b0) begin fails++; $display("FAIL p_pulse_width: update_done=%b want 0", update_done); end
  endtask

  task automatic test_deadband;
    int cyc;
    logic [23:0] sp [3] = '{24'd104, 24'd105, 24'd106};
    int          ex [3] = '{0, 0, 60};
    deadband = 24'd5; encoder0_position = 24'd100;
    for (int i = 0; i < 3; i++) begin
      setpoint = sp[i];
      wait_update(cyc);
      tests++;
      if (cyc < 0 || duty !== 24'(ex[i])) begin
        fails++; $display("FAIL deadband[%0d]: got %0d want %0d (cyc %0d)", i, $signed(duty), ex[i], cyc);
      end
    end
    deadband = 24'd0; encoder0_position = 24'd0;
  endtask

  task automatic test_saturation;
    int cyc;
    logic [23:0] sp [3] = '{24'd100, -24'sd100, 24'd100};
    logic [23:0] pl [3] = '{24'd500, 24'd500, 24'd0};
    int          ex [3] = '{500, -500, 0};
    for (int i = 0; i < 3; i++) begin
      setpoint = sp[i]; PWMLimit = pl[i];
      wait_update(cyc);
      tests++;
      if (cyc < 0 || duty !== 24'(ex[i])) begin
        fails++; $display("FAIL saturation[%0d]: got %0d want %0d", i, $signed(duty), ex[i]);
      end
    end
    PWMLimit = 24'd8388607;
  endtask

  task automatic test_integral;
    int cyc;
    int ex [4] = '{10, 20, 25, 25};
    Kp = 24'd0; Ki = 24'd1; Kd = 24'd0; IntegralLimit = 24'd25;
    setpoint = 24'd10; encoder0_position = 24'd0;
    for (int i = 0; i < 4; i++) begin
      wait_update(cyc);
      tests++;
      if (cyc < 0 || duty !== 24'(ex[i])) begin
        fails++; $display("FAIL integral[%0d]: got %0d want %0d", i, $signed(duty), ex[i]);
      end
    end
    control_mode = 8'd1;
    wait_update(cyc);
    tests++;
    if (cyc < 0 || duty !== 24'd10) begin
      fails++; $display("FAIL integral_mode_clear: got %0d want 10", $signed(duty));
    end
    Ki = 24'd0;
  endtask

  task automatic test_velocity;
    int cyc;
    logic [23:0] enc [3] = '{24'd5000, 24'd8388600, -24'sd8388606};
    int          ex  [3] = '{0, -8383600, -10};
    @(negedge CLK) reset = 1'b1;
    control_mode = 8'd1; Kp = 24'd1; Ki = 24'd0; Kd = 24'd0; setpoint = 24'd0;
    PWMLimit = 24'd8388607; deadband = 24'd0;
    @(negedge CLK);
    @(negedge CLK) reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      encoder0_position = enc[i];
      wait_update(cyc);
      tests++;
      if (cyc < 0 || duty !== 24'(ex[i])) begin
        fails++; $display("FAIL velocity[%0d]: got %0d want %0d", i, $signed(duty), ex[i]);
      end
    end
  endtask

  task automatic test_derivative;
    int cyc;
    logic [23:0] sp [3] = '{24'd50, 24'd50, 24'd30};
    int          ex [3] = '{100, 0, -40};
    control_mode = 8'd0; Kp = 24'd0; Ki = 24'd0; Kd = 24'd2; encoder0_position = 24'd0;
    for (int i = 0; i < 3; i++) begin
      setpoint = sp[i];
      wait_update(cyc);
      tests++;
      if (cyc < 0 || duty !== 24'(ex[i])) begin
        fails++; $display("FAIL derivative[%0d]: got %0d want %0d", i, $signed(duty), ex[i]);
      end
    end
    Kd = 24'd0;
  endtask

  task automatic test_direct;
    int cyc;
    logic [7:0]  md [4] = '{8'd3, 8'd3, 8'd7, 8'd3};
    logic [23:0] sp [4] = '{-24'sd300, 24'd150, 24'd150, -24'sd300};
    int          ex [4] = '{-200, 150, 0, -200};
    PWMLimit = 24'd200;
    for (int i = 0; i < 4; i++) begin
      control_mode = md[i]; setpoint = sp[i];
      wait_update(cyc);
      tests++;
      if (cyc < 0 || duty !== 24'(ex[i])) begin
        fails++; $display("FAIL direct[%0d]: got %0d want %0d", i, $signed(duty), ex[i]);
      end
    end
  endtask

  // Entered just after an update_done edge; next tick is sampled P-6 edges later.
  task automatic test_reset_abort;
    logic bad;
    bad = 1'b0;
    repeat (P - 4) @(posedge CLK);
    @(negedge CLK) reset = 1'b1;   // sampled 3 cycles after the tick edge
    @(negedge CLK) reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      if (duty !== 24'd0 || update_done !== 1'b0) bad = 1'b1;
    end
    tests++;
    if (bad) begin fails++; $display("FAIL reset_abort: duty=%0d done=%b want 0/0", $signed(duty), update_done); end
  endtask

  initial begin
    test_reset();
    test_p_basic();
    test_deadband();
    test_saturation();
    test_integral();
    test_velocity();
    test_derivative();
    test_direct();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
